sync_fifo: RTL and testbench

Single-clock, parametrised FIFO: the same-domain successor to the dual-clock FIFO. It adds arbitrary (non-power-of-two) depth, an occupancy count, almost-full and almost-empty thresholds, and a selectable read mode (first-word-fall-through or registered), plus optional sticky overflow/underflow flags. It sits between producer and consumer logic that share one clock, where gray-code pointer synchronisation is unnecessary.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_memory.sv | 27 ++
 rtl/sync_fifo.sv | 152 +++++++++++++++
 tb/tb_sync_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and width helpers for the single-clock FIFO.
package sync_fifo_pkg;

    // Read-mode selectors for the FWFT parameter.
    localparam int unsigned FIFO_MODE_REGISTERED = 0;
    localparam int unsigned FIFO_MODE_FWFT       = 1;

    // Pointer width: enough bits to index FIFO_DEPTH entries (never below 1).
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: enough bits to represent 0..FIFO_DEPTH inclusive.
    function automatic int unsigned count_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_memory.sv
// sync_fifo_memory: FIFO_DEPTH x FIFO_DATA_WIDTH flop array with one
// synchronous write port and one combinational read port. Contents are not reset.
module sync_fifo_memory #(
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned ADDR_BITS       = 3
) (
    input  logic                       clk,
    input  logic                       write_en,
    input  logic [ADDR_BITS-1:0]       write_addr,
    input  logic [FIFO_DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_BITS-1:0]       read_addr,
    output logic [FIFO_DATA_WIDTH-1:0] read_data
);

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Store the write payload at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds and FWFT or registered read mode.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH          = 8,
    parameter int unsigned FWFT                = FIFO_MODE_FWFT,
    parameter int unsigned ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                fifo_push,
    input  logic [FIFO_DATA_WIDTH-1:0]          write_data,
    output logic                                fifo_full,
    output logic                                fifo_almost_full,
    input  logic                                fifo_pop,
    output logic [FIFO_DATA_WIDTH-1:0]          read_data,
    output logic                                read_data_valid,
    output logic                                fifo_empty,
    output logic                                fifo_almost_empty,
    output logic [count_bits(FIFO_DEPTH)-1:0]   fifo_count,
    output logic                                overflow_err,
    output logic                                underflow_err
);

    localparam int unsigned ADDR_BITS  = addr_bits(FIFO_DEPTH);
    localparam int unsigned COUNT_BITS = count_bits(FIFO_DEPTH);

    localparam logic [ADDR_BITS-1:0]  LAST_PTR  = ADDR_BITS'(FIFO_DEPTH - 1);
    localparam logic [COUNT_BITS-1:0] DEPTH_CNT = COUNT_BITS'(FIFO_DEPTH);
    localparam logic [COUNT_BITS-1:0] AF_LEVEL  = COUNT_BITS'(ALMOST_FULL_THRESH);
    localparam logic [COUNT_BITS-1:0] AE_LEVEL  = COUNT_BITS'(ALMOST_EMPTY_THRESH);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be at least 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("sync_fifo: ALMOST_FULL_THRESH must lie in 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: ALMOST_EMPTY_THRESH must lie in 0..FIFO_DEPTH-1");
    end
    if (FWFT != FIFO_MODE_FWFT && FWFT != FIFO_MODE_REGISTERED) begin : g_bad_mode
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [ADDR_BITS-1:0]       write_ptr;
    logic [ADDR_BITS-1:0]       read_ptr;
    logic [COUNT_BITS-1:0]      count;
    logic                       read_en;
    logic                       write_en;
    logic [FIFO_DATA_WIDTH-1:0] mem_read_data;

    // Status flags decode the count register only, so they never follow push/pop combinationally.
    assign fifo_empty        = (count == '0);
    assign fifo_full         = (count == DEPTH_CNT);
    assign fifo_almost_full  = (count >= AF_LEVEL);
    assign fifo_almost_empty = (count <= AE_LEVEL);
    assign fifo_count        = count;

    // A push while full is accepted only when a pop frees the slot in the same cycle.
    assign read_en  = fifo_pop && !fifo_empty;
    assign write_en = fifo_push && (!fifo_full || read_en);

    sync_fifo_memory #(
        .FIFO_DATA_WIDTH (FIFO_DATA_WIDTH),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .ADDR_BITS       (ADDR_BITS)
    ) u_memory (
        .clk        (clk),
        .write_en   (write_en && !reset),
        .write_addr (write_ptr),
        .write_data (write_data),
        .read_addr  (read_ptr),
        .read_data  (mem_read_data)
    );

    // Advance pointers with an explicit wrap at FIFO_DEPTH-1 and track occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (write_en) begin
                write_ptr <= (write_ptr == LAST_PTR) ? '0 : write_ptr + ADDR_BITS'(1);
            end
            if (read_en) begin
                read_ptr <= (read_ptr == LAST_PTR) ? '0 : read_ptr + ADDR_BITS'(1);
            end
            case ({write_en, read_en})
                2'b10:   count <= count + COUNT_BITS'(1);
                2'b01:   count <= count - COUNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign read_data       = mem_read_data;
        assign read_data_valid = !fifo_empty;
    end else begin : g_registered
        logic [FIFO_DATA_WIDTH-1:0] read_data_q;
        logic                       read_valid_q;

        // Capture the head word on an accepted pop; valid pulses for the following cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                read_data_q  <= '0;
                read_valid_q <= 1'b0;
            end else begin
                read_valid_q <= read_en;
                if (read_en) begin
                    read_data_q <= mem_read_data;
                end
            end
        end

        assign read_data       = read_data_q;
        assign read_data_valid = read_valid_q;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags: set on a dropped push or a pop while empty, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo_push && !write_en) begin
                overflow_q <= 1'b1;
            end
            if (fifo_pop && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives a DEPTH=8 FWFT instance and a DEPTH=5 registered-read
// instance, checking both against queue-based reference models.
module tb_sync_fifo;

    localparam int unsigned DA = 8;
    localparam int unsigned DB = 5;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_push = 1'b0, a_pop = 1'b0;
    logic [7:0] a_wdata = '0;
    logic       a_full, a_af, a_valid, a_empty, a_ae, a_ovf, a_unf;
    logic [7:0] a_rdata;
    logic [3:0] a_count;

    logic       b_push = 1'b0, b_pop = 1'b0;
    logic [7:0] b_wdata = '0;
    logic       b_full, b_af, b_valid, b_empty, b_ae, b_ovf, b_unf;
    logic [7:0] b_rdata;
    logic [2:0] b_count;

    int checks   = 0;
    int failures = 0;

    // Reference state: queue contents, sticky error bits, registered-read output.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         ovf_a, unf_a, ovf_b, unf_b;
    logic [7:0] exp_rdb;
    bit         exp_vb;

    always #5 clk = ~clk;

    sync_fifo #(
        .FIFO_DATA_WIDTH (8),
        .FIFO_DEPTH      (DA),
        .FWFT            (1)
    ) u_a (
        .clk               (clk),
        .reset             (rst),
        .fifo_push         (a_push),
        .write_data        (a_wdata),
        .fifo_full         (a_full),
        .fifo_almost_full  (a_af),
        .fifo_pop          (a_pop),
        .read_data         (a_rdata),
        .read_data_valid   (a_valid),
        .fifo_empty        (a_empty),
        .fifo_almost_empty (a_ae),
        .fifo_count        (a_count),
        .overflow_err      (a_ovf),
        .underflow_err     (a_unf)
    );

    sync_fifo #(
        .FIFO_DATA_WIDTH (8),
        .FIFO_DEPTH      (DB),
        .FWFT            (0)
    ) u_b (
        .clk               (clk),
        .reset             (rst),
        .fifo_push         (b_push),
        .write_data        (b_wdata),
        .fifo_full         (b_full),
        .fifo_almost_full  (b_af),
        .fifo_pop          (b_pop),
        .read_data         (b_rdata),
        .read_data_valid   (b_valid),
        .fifo_empty        (b_empty),
        .fifo_almost_empty (b_ae),
        .fifo_count        (b_count),
        .overflow_err      (b_ovf),
        .underflow_err     (b_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One FIFO as a queue: pop the head if any, then append if there is room.
    task automatic model_a(input bit r, input bit push, input bit pop, input logic [7:0] d);
        bit rd_ok, wr_ok;
        if (r) begin
            qa.delete(); ovf_a = 0; unf_a = 0;
        end else begin
            rd_ok = pop && (qa.size() != 0);
            wr_ok = push && ((qa.size() < DA) || rd_ok);
            if (push && !wr_ok) ovf_a = 1;
            if (pop && qa.size() == 0) unf_a = 1;
            if (rd_ok) void'(qa.pop_front());
            if (wr_ok) qa.push_back(d);
        end
    endtask

    task automatic model_b(input bit r, input bit push, input bit pop, input logic [7:0] d);
        bit rd_ok, wr_ok;
        if (r) begin
            qb.delete(); ovf_b = 0; unf_b = 0; exp_rdb = '0; exp_vb = 0;
        end else begin
            rd_ok = pop && (qb.size() != 0);
            wr_ok = push && ((qb.size() < DB) || rd_ok);
            if (push && !wr_ok) ovf_b = 1;
            if (pop && qb.size() == 0) unf_b = 1;
            exp_vb = rd_ok;
            if (rd_ok) exp_rdb = qb.pop_front();
            if (wr_ok) qb.push_back(d);
        end
    endtask

    task automatic check_models();
        chk("a_count",  32'(a_count), 32'(qa.size()));
        chk("a_empty",  32'(a_empty), 32'(qa.size() == 0));
        chk("a_full",   32'(a_full),  32'(qa.size() == DA));
        chk("a_afull",  32'(a_af),    32'(qa.size() >= 6));
        chk("a_aempty", 32'(a_ae),    32'(qa.size() <= 2));
        chk("a_valid",  32'(a_valid), 32'(qa.size() != 0));
        if (qa.size() != 0) chk("a_rdata", 32'(a_rdata), 32'(qa[0]));
        chk("a_ovf",    32'(a_ovf),   32'(ERR_EN && ovf_a));
        chk("a_unf",    32'(a_unf),   32'(ERR_EN && unf_a));
        chk("b_count",  32'(b_count), 32'(qb.size()));
        chk("b_empty",  32'(b_empty), 32'(qb.size() == 0));
        chk("b_full",   32'(b_full),  32'(qb.size() == DB));
        chk("b_afull",  32'(b_af),    32'(qb.size() >= 3));
        chk("b_aempty", 32'(b_ae),    32'(qb.size() <= 2));
        chk("b_valid",  32'(b_valid), 32'(exp_vb));
        chk("b_rdata",  32'(b_rdata), 32'(exp_rdb));
        chk("b_ovf",    32'(b_ovf),   32'(ERR_EN && ovf_b));
        chk("b_unf",    32'(b_unf),   32'(ERR_EN && unf_b));
    endtask

    // Drive both instances for one cycle, advance the models, then compare.
    task automatic tick(input bit r, input bit ap, input bit apo, input logic [7:0] ad,
                        input bit bp, input bit bpo, input logic [7:0] bd);
        rst = r; a_push = ap; a_pop = apo; a_wdata = ad;
        b_push = bp; b_pop = bpo; b_wdata = bd;
        @(posedge clk);
        model_a(r, ap, apo, ad);
        model_b(r, bp, bpo, bd);
        #1;
        check_models();
    endtask

    typedef struct {
        bit         rst;
        bit         push;
        bit         pop;
        logic [7:0] data;
        int         exp_count;
        bit         exp_full;
        bit         exp_af;
        bit         exp_empty;
        bit         exp_valid;
        logic [7:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit p, input bit q, input logic [7:0] d,
                                input int c, input bit f, input bit af, input bit e,
                                input bit v, input logic [7:0] rd);
        vec_t x;
        x.rst = r; x.push = p; x.pop = q; x.data = d;
        x.exp_count = c; x.exp_full = f; x.exp_af = af; x.exp_empty = e;
        x.exp_valid = v; x.exp_rd = rd;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        // Reset, fill 0..7, drop a 9th push, drain in order, one extra pop.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 8'(i - 1), i, i == 8, i >= 6, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h08, 8, 1, 1, 0, 1, 8'h00));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 1, 8'h00, 8 - k, 0, (8 - k) >= 6, k == 8, k != 8, 8'(k)));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].data, 0, 0, 8'h00);
            chk("vec_count", 32'(a_count), 32'(vecs[i].exp_count));
            chk("vec_full",  32'(a_full),  32'(vecs[i].exp_full));
            chk("vec_afull", 32'(a_af),    32'(vecs[i].exp_af));
            chk("vec_empty", 32'(a_empty), 32'(vecs[i].exp_empty));
            chk("vec_valid", 32'(a_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk("vec_rdata", 32'(a_rdata), 32'(vecs[i].exp_rd));
        end
        chk("ovf_after_fill",  32'(a_ovf), 32'(ERR_EN));
        chk("unf_after_drain", 32'(a_unf), 32'(ERR_EN));

        // Registered read: word appears exactly one cycle after the pop edge, then valid drops.
        tick(1, 0, 0, 8'h00, 0, 0, 8'h00);
        tick(0, 0, 0, 8'h00, 1, 0, 8'hA5);
        chk("reg_empty_after_push", 32'(b_empty), 32'd0);
        chk("reg_valid_before_pop", 32'(b_valid), 32'd0);
        tick(0, 0, 0, 8'h00, 0, 1, 8'h00);
        chk("reg_valid_pop", 32'(b_valid), 32'd1);
        chk("reg_rdata_pop", 32'(b_rdata), 32'hA5);
        tick(0, 0, 0, 8'h00, 0, 0, 8'h00);
        chk("reg_valid_drop", 32'(b_valid), 32'd0);
        chk("reg_rdata_hold", 32'(b_rdata), 32'hA5);

        // Full with push+pop every cycle for 10 cycles on A; wrap-around interleave on B.
        tick(1, 0, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) tick(0, 1, 0, 8'(8'h10 + i), 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick(0, i < 10, i < 10, 8'(8'h80 + i), 1, (i >= 2) && (i % 3 != 0), 8'(8'h40 + i));
            if (i < 10) chk("full_pp_count", 32'(a_count), 32'd8);
            chk("b_count_bound", 32'(b_count <= 3'd5), 32'd1);
        end
        chk("full_pp_ovf", 32'(a_ovf), 32'd0);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 8'h00, 0, 1, 8'h00);

        // Reset with three entries held discards them; a fresh push reads back.
        tick(1, 0, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'(8'h11 * (i + 1)), 1, 0, 8'(8'h11 * (i + 1)));
        chk("pre_reset_count_a", 32'(a_count), 32'd3);
        chk("pre_reset_count_b", 32'(b_count), 32'd3);
        tick(1, 1, 1, 8'hEE, 1, 1, 8'hEE);
        chk("reset_count_a", 32'(a_count), 32'd0);
        chk("reset_empty_a", 32'(a_empty), 32'd1);
        chk("reset_count_b", 32'(b_count), 32'd0);
        chk("reset_valid_b", 32'(b_valid), 32'd0);
        tick(0, 1, 0, 8'h01, 1, 0, 8'h01);
        chk("post_reset_rdata_a", 32'(a_rdata), 32'h01);
        tick(0, 0, 1, 8'h00, 0, 1, 8'h00);
        chk("post_reset_rdata_b", 32'(b_rdata), 32'h01);
        chk("post_reset_valid_b", 32'(b_valid), 32'd1);

        // Random traffic, push-heavy then pop-heavy, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            int unsigned pb;
            bit r;
            pb = (n < 300) ? 70 : 35;
            r  = ($urandom_range(0, 63) == 0);
            tick(r,
                 $urandom_range(0, 99) < pb, $urandom_range(0, 99) < 50, 8'($urandom),
                 $urandom_range(0, 99) < pb, $urandom_range(0, 99) < 50, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
